// File: rtl/approx_fir_mac_pkg.sv
// Shared types and helpers for the approx_fir_mac tap engine: FSM encoding,
// datapath widths and the sign/magnitude split used ahead of the unsigned multiplier.
package approx_fir_mac_pkg;

    localparam int DATA_W = 8;
    localparam int PROD_W = 16;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_FLUSH,
        ST_OUT
    } state_t;

    // -128 maps to 8'h80, which reads as +128 once treated as unsigned.
    function automatic logic [DATA_W-1:0] mag8(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 8'd1) : v;
    endfunction

    // A zero operand forces a positive product so the accumulator never sees -0.
    function automatic logic neg_sign(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] h);
        return (x[DATA_W-1] ^ h[DATA_W-1]) && (x != '0) && (h != '0);
    endfunction

endpackage

// File: rtl/approx_fir_mac_mult.sv
// 8x8 unsigned approximate multiplier: each operand keeps only its four most
// significant bits counted from the leading one, so operands below 16 multiply exactly.
module unsignedApproxMult
    import approx_fir_mac_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    function automatic logic [DATA_W-1:0] keep_top4(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] mask;
        if (v[7])      mask = 8'hF0;
        else if (v[6]) mask = 8'hF8;
        else if (v[5]) mask = 8'hFC;
        else if (v[4]) mask = 8'hFE;
        else           mask = 8'hFF;
        return v & mask;
    endfunction

    logic [PROD_W-1:0] a_t;
    logic [PROD_W-1:0] b_t;

    assign a_t = PROD_W'(keep_top4(a));
    assign b_t = PROD_W'(keep_top4(b));
    assign p   = a_t * b_t;

endmodule

// File: rtl/approx_fir_mac.sv
// Time-multiplexed FIR tap engine for one filter-bank channel, one tap per cycle
// through unsignedApproxMult. Define OUT_SAT_EN to saturate the output instead of wrapping.
module approx_fir_mac
    import approx_fir_mac_pkg::*;
#(
    parameter int TAPS      = 16,
    parameter int ACC_W     = 24,
    parameter int OUT_SHIFT = 7
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [DATA_W-1:0] coef_wdata,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [DATA_W-1:0] x_data,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [OUT_W-1:0]  y_data
);

    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] dline [TAPS];
    logic [DATA_W-1:0] coef  [TAPS];

    logic [IDX_W-1:0] wptr;
    logic [IDX_W-1:0] rptr;
    logic [IDX_W-1:0] tap;

    logic signed [ACC_W-1:0] acc;
    logic [PROD_W-1:0]       prod_q;
    logic                    prod_neg_q;
    logic                    prod_vld;

    logic              accept;
    logic              last_tap;
    logic              coef_hit;
    logic [DATA_W-1:0] x_op;
    logic [DATA_W-1:0] h_op;
    logic [PROD_W-1:0] mult_p;
    logic [ACC_W-1:0]  prod_mag;
    logic signed [ACC_W-1:0] prod_ext;
    logic [OUT_W-1:0]  y_next;

    assign accept   = x_valid && x_ready;
    assign last_tap = (tap == LAST_IDX);
    assign coef_hit = coef_we && (state == ST_IDLE) && (int'(coef_addr) < TAPS);

    // rptr walks backwards from the newest sample, so tap k sees x[n-k].
    assign x_op = dline[rptr];
    assign h_op = coef[tap];

    unsignedApproxMult u_mult (
        .a (mag8(x_op)),
        .b (mag8(h_op)),
        .p (mult_p)
    );

    assign prod_mag = ACC_W'(prod_q);
    assign prod_ext = $signed(prod_neg_q ? (~prod_mag + 1'b1) : prod_mag);

`ifdef OUT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    logic signed [ACC_W-1:0] acc_sh;
    logic signed [ACC_W-1:0] acc_sat;

    assign acc_sh = acc >>> OUT_SHIFT;

    always_comb begin
        acc_sat = acc_sh;
        if (acc_sh > SAT_MAX)
            acc_sat = SAT_MAX;
        else if (acc_sh < SAT_MIN)
            acc_sat = SAT_MIN;
    end

    assign y_next = acc_sat[OUT_W-1:0];
`else
    assign y_next = OUT_W'(acc >>> OUT_SHIFT);
`endif

    always_comb begin
        state_nxt = state;
        x_ready   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                x_ready = 1'b1;
                if (x_valid)
                    state_nxt = ST_MAC;
            end
            ST_MAC: begin
                if (last_tap)
                    state_nxt = ST_FLUSH;
            end
            ST_FLUSH: state_nxt = ST_OUT;
            ST_OUT: begin
                if (y_valid && y_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wptr       <= '0;
            rptr       <= '0;
            tap        <= '0;
            acc        <= '0;
            prod_q     <= '0;
            prod_neg_q <= 1'b0;
            prod_vld   <= 1'b0;
            y_valid    <= 1'b0;
            y_data     <= '0;
            for (int i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            state    <= state_nxt;
            prod_vld <= (state == ST_MAC);

            if (coef_hit)
                coef[coef_addr[IDX_W-1:0]] <= coef_wdata;

            if (state == ST_MAC) begin
                prod_q     <= mult_p;
                prod_neg_q <= neg_sign(x_op, h_op);
                tap        <= tap + 1'b1;
                rptr       <= (rptr == '0) ? LAST_IDX : rptr - 1'b1;
            end

            if (accept) begin
                dline[wptr] <= x_data;
                rptr        <= wptr;
                wptr        <= (wptr == LAST_IDX) ? '0 : wptr + 1'b1;
                acc         <= '0;
                tap         <= '0;
            end else if (prod_vld) begin
                acc <= acc + prod_ext;
            end

            // First OUT cycle loads the result; afterwards it is held until taken.
            if (state == ST_OUT && !y_valid) begin
                y_valid <= 1'b1;
                y_data  <= y_next;
            end else if (y_valid && y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_approx_fir_mac.sv
// Directed bench for approx_fir_mac with a sum-of-products reference model and a
// per-cycle output checker; follows OUT_SAT_EN the same way the design does.
module tb_approx_fir_mac;

    localparam int TAPS = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              coef_we;
    logic [5:0]        coef_addr;
    logic [7:0]        coef_wdata;
    logic              x_valid;
    logic              x_ready;
    logic [7:0]        x_data;
    logic              y_valid;
    logic              y_ready;
    logic signed [15:0] y_data;

    approx_fir_mac #(.TAPS(TAPS), .ACC_W(24), .OUT_SHIFT(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_data     (x_data),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_data     (y_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    chk_t               cq[$];
    logic signed [15:0] exq[$];
    int                 hist[TAPS];
    int                 cf[TAPS];
    int                 n_tests = 0;
    int                 n_fail  = 0;

    // Approximate operand: only the four leading bits of the magnitude survive.
    function automatic int apx(input int v);
        int len;
        len = 0;
        for (int t = v; t > 0; t = t >> 1) len++;
        if (len > 4) return (v >> (len - 4)) << (len - 4);
        return v;
    endfunction

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic signed [15:0] model_y();
        longint acc;
        int     m;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            m = apx(absi(hist[k])) * apx(absi(cf[k]));
            acc += ((hist[k] < 0) != (cf[k] < 0)) ? -m : m;
        end
`ifdef OUT_SAT_EN
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
`endif
        return acc[15:0];
    endfunction

    // Reference model: tracks coefficients and sample history at each clock edge.
    always @(posedge clk) begin
        if (rst) begin
            exq.delete();
            for (int k = 0; k < TAPS; k++) begin
                hist[k] = 0;
                cf[k]   = 0;
            end
        end else begin
            if (y_valid && y_ready && exq.size() > 0)
                void'(exq.pop_front());
            if (coef_we && x_ready && int'(coef_addr) < TAPS)
                cf[int'(coef_addr)] = int'($signed(coef_wdata));
            if (x_valid && x_ready) begin
                for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'($signed(x_data));
                exq.push_back(model_y());
            end
        end
    end

    // Single checker: drains directed checks and compares outputs every cycle.
    always @(negedge clk) begin
        while (cq.size() > 0) begin
            chk_t c;
            c = cq.pop_front();
            n_tests++;
            if (c.act != c.exp) begin
                n_fail++;
                $display("FAIL %s: actual %0d, required %0d", c.name, c.act, c.exp);
            end
        end
        if (!rst && y_valid) begin
            n_tests++;
            if (exq.size() == 0) begin
                n_fail++;
                $display("FAIL y_unexpected: actual %0d, required no output", y_data);
            end else if (y_data !== exq[0]) begin
                n_fail++;
                $display("FAIL y_model: actual %0d, required %0d", y_data, exq[0]);
            end
            n_tests++;
            if (x_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL x_ready_busy: actual %0b, required 0", x_ready);
            end
        end
    end

    function automatic void post(input string n, input int a, input int e);
        chk_t c;
        c.name = n;
        c.act  = a;
        c.exp  = e;
        cq.push_back(c);
    endfunction

    task automatic wr_coef(input int a, input int d);
        coef_we    = 1'b1;
        coef_addr  = 6'(a);
        coef_wdata = 8'(d);
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    // One sample end to end; optional same-cycle coef write, mid-MAC coef write, output stall.
    task automatic run_sample(input int x, input int stall, input int we_addr, input int we_data,
                              input int mac_we_at, output int y);
        int n;
        int lat;
        n = 0;
        while (!x_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        post("x_ready_wait", int'(x_ready), 1);
        x_valid = 1'b1;
        x_data  = 8'(x);
        if (we_addr >= 0) begin
            coef_we    = 1'b1;
            coef_addr  = 6'(we_addr);
            coef_wdata = 8'(we_data);
        end
        @(posedge clk); #1;
        x_valid = 1'b0;
        coef_we = 1'b0;
        lat = 0;
        while (!y_valid && lat < 100) begin
            if (lat == mac_we_at) begin
                coef_we    = 1'b1;
                coef_addr  = 6'd0;
                coef_wdata = 8'd50;
            end
            @(posedge clk); #1;
            coef_we = 1'b0;
            lat++;
        end
        post("latency", lat, TAPS + 2);
        y = int'(y_data);
        if (stall > 0) begin
            x_valid = 1'b1;
            x_data  = 8'd55;
            repeat (stall) begin
                @(posedge clk); #1;
                post("hold_valid", int'(y_valid), 1);
                post("hold_data", int'(y_data), y);
                post("hold_xready", int'(x_ready), 0);
            end
        end
        y_ready = 1'b1;
        @(posedge clk); #1;
        y_ready = 1'b0;
        x_valid = 1'b0;
        post("post_hs_valid", int'(y_valid), 0);
        post("post_hs_data", int'(y_data), y);
        post("post_hs_xready", int'(x_ready), 1);
    endtask

    initial begin
        int y;
        rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        post("rst_y_valid", int'(y_valid), 0);
        post("rst_x_ready", int'(x_ready), 1);
        post("rst_y_data", int'(y_data), 0);

        // Impulse through h[k]=k+1: exact small-operand products.
        for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
        for (int n = 0; n < TAPS; n++) begin
            run_sample((n == 0) ? 8 : 0, 0, -1, 0, -1, y);
            post($sformatf("impulse_%0d", n), y, 8 * (n + 1));
        end

        // Full-scale: 16 x (120*120) = 230400 overflows 16 bits.
        for (int k = 0; k < TAPS; k++) wr_coef(k, 127);
        for (int n = 0; n < TAPS; n++) run_sample(127, 0, -1, 0, -1, y);
`ifdef OUT_SAT_EN
        post("sat_full", y, 32767);
`else
        post("wrap_full", y, -31744);
`endif

        // Single-tap approximation and sign handling.
        for (int k = 0; k < TAPS; k++) wr_coef(k, (k == 0) ? 100 : 0);
        run_sample(100, 0, -1, 0, -1, y);
        post("apx_pos", y, 9216);
        run_sample(-100, 0, -1, 0, -1, y);
        post("apx_neg", y, -9216);
        run_sample(-100, 0, 0, -100, -1, y);
        post("coef_with_accept", y, 9216);
        wr_coef(20, 5);
        run_sample(-128, 0, -1, 0, -1, y);
        post("min_sample", y, 12288);

        // Output stall with a pending sample offered.
        run_sample(7, 10, -1, 0, -1, y);
        post("stall_value", y, -672);

        // Coefficient write during MAC must be dropped.
        run_sample(4, 0, -1, 0, 3, y);
        post("mac_we_first", y, -384);
        run_sample(4, 0, -1, 0, -1, y);
        post("mac_we_dropped", y, -384);

        // Reset while tap 5 is in flight.
        x_valid = 1'b1;
        x_data  = 8'd50;
        @(posedge clk); #1;
        x_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        post("abort_y_valid", int'(y_valid), 0);
        post("abort_x_ready", int'(x_ready), 1);
        run_sample(8, 0, -1, 0, -1, y);
        post("cleared_impulse0", y, 0);
        run_sample(0, 0, -1, 0, -1, y);
        post("cleared_impulse1", y, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
